interleave_wr_ctrl: RTL and testbench

INTERLEAVE_WR_CTRL -- requirements
Module: interleave_wr_ctrl

---
 rtl/interleave_wr_ctrl.sv | 177 +++++++++++++++++
 tb/tb_interleave_wr_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleave_wr_ctrl.sv
// Write side of the 802.11a/g block interleaver.
// Coded bits arrive serially and are written one bit per cycle into a
// two-bank (ping-pong) RAM at the first/second permutation address, so
// the reader can pull each subcarrier row out in order.
//
// Bank states (one per bank, held in full_q):
//   state | meaning
//   FREE  | bank may be written by the incoming symbol
//   FULL  | bank holds a complete symbol waiting for the reader
module interleave_wr_ctrl #(
    parameter int NROW = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mod_sel,
    input  logic       bit_i,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [9:0] ram_waddr,
    output logic       ram_wen,
    output logic       ram_wdata,
    output logic       sym_valid,
    output logic       sym_bank,
    input  logic       sym_release
);

    logic [8:0] k_q, k_d;
    logic [1:0] mode_q, mode_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [1:0] full_q, full_d;
    logic       pend_q, pend_d;
    logic       pend_bank_q, pend_bank_d;
    logic       bit_ready_q, bit_ready_d;
    logic       ram_wen_q, ram_wen_d;
    logic [9:0] ram_waddr_q, ram_waddr_d;
    logic       ram_wdata_q, ram_wdata_d;

    logic       accept;
    logic [1:0] eff_mode;
    logic [8:0] last_k;
    logic [3:0] col;
    logic [4:0] sub;
    logic [5:0] col3;
    logic [5:0] row_w;
    logic [2:0] pos_w;
    logic [1:0] sub_div6;
    logic       sub_div3_odd;
    logic [1:0] sub_mod3;
    logic [1:0] col_mod3;
    logic [1:0] rot;

    assign accept = bit_valid & bit_ready_q;

    // Row/position of bit k. With c = k mod 16 and r = k / 16 the first
    // permutation gives i = 3*N_BPSC*c + r, and floor(16*i/N_CBPS) is just c,
    // so each mode collapses to a row of 3*c plus a small term in r, and the
    // second permutation becomes a rotation by c inside groups of s bits.
    always_comb begin
        eff_mode     = (k_q == 9'd0) ? mod_sel : mode_q;
        col          = k_q[3:0];
        sub          = k_q[8:4];
        col3         = {1'b0, col, 1'b0} + {2'b00, col};
        sub_div6     = 2'(sub / 5'd6);
        sub_div3_odd = 1'(sub / 5'd3);
        sub_mod3     = 2'(sub % 5'd3);
        col_mod3     = 2'(col % 4'd3);
        rot          = (sub_mod3 >= col_mod3) ? (sub_mod3 - col_mod3)
                                              : (sub_mod3 + 2'd3 - col_mod3);
        row_w        = col3;
        pos_w        = 3'd0;
        last_k       = 9'(NROW - 1);
        case (eff_mode)
            2'd0: begin
                row_w  = col3 + {1'b0, sub};
                pos_w  = 3'd0;
                last_k = 9'(NROW - 1);
            end
            2'd1: begin
                row_w  = col3 + {2'b00, sub[4:1]};
                pos_w  = {2'b00, sub[0]};
                last_k = 9'(2 * NROW - 1);
            end
            2'd2: begin
                row_w  = col3 + {3'b000, sub[4:2]};
                pos_w  = {1'b0, sub[1], sub[0] ^ col[0]};
                last_k = 9'(4 * NROW - 1);
            end
            default: begin
                row_w  = col3 + {4'b0000, sub_div6};
                pos_w  = (sub_div3_odd ? 3'd3 : 3'd0) + {1'b0, rot};
                last_k = 9'(6 * NROW - 1);
            end
        endcase
    end

    // Accept, bank bookkeeping (fill, delayed FULL mark, release) and
    // the registered RAM write port.
    always_comb begin
        k_d         = k_q;
        mode_d      = mode_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        full_d      = full_q;
        pend_d      = 1'b0;
        pend_bank_d = pend_bank_q;
        ram_wen_d   = accept;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;

        // FULL lands one cycle after the last write so the reader never
        // sees a bank whose final bit is still in flight.
        if (pend_q) begin
            full_d[pend_bank_q] = 1'b1;
        end

        if (sym_release && full_q[rb_q]) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end

        if (accept) begin
            ram_waddr_d = {wb_q, row_w, pos_w};
            ram_wdata_d = bit_i;
            if (k_q == 9'd0) begin
                mode_d = mod_sel;
            end
            if (k_q == last_k) begin
                k_d         = 9'd0;
                wb_d        = ~wb_q;
                pend_d      = 1'b1;
                pend_bank_d = wb_q;
            end else begin
                k_d = k_q + 9'd1;
            end
        end

        bit_ready_d = ~full_d[wb_d];
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= 9'd0;
            mode_q      <= 2'd0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= 2'b00;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            bit_ready_q <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_waddr_q <= 10'd0;
            ram_wdata_q <= 1'b0;
        end else begin
            k_q         <= k_d;
            mode_q      <= mode_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            bit_ready_q <= bit_ready_d;
            ram_wen_q   <= ram_wen_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign bit_ready = bit_ready_q;
    assign ram_wen   = ram_wen_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;
    assign sym_valid = full_q[rb_q];
    assign sym_bank  = rb_q;

endmodule

// File: tb/tb_interleave_wr_ctrl.sv
// Directed bench for interleave_wr_ctrl: hand-picked addresses, bank
// ping-pong handshakes, reset behaviour, plus full-symbol sweeps checked
// against the textbook permutation formula.
module tb_interleave_wr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mod_sel;
    logic       bit_i;
    logic       bit_valid;
    logic       bit_ready;
    logic [9:0] ram_waddr;
    logic       ram_wen;
    logic       ram_wdata;
    logic       sym_valid;
    logic       sym_bank;
    logic       sym_release;

    int checks   = 0;
    int failures = 0;
    int hits[1024];

    interleave_wr_ctrl #(.NROW(48)) dut (
        .clk        (clk),
        .rst        (rst),
        .mod_sel    (mod_sel),
        .bit_i      (bit_i),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .ram_waddr  (ram_waddr),
        .ram_wen    (ram_wen),
        .ram_wdata  (ram_wdata),
        .sym_valid  (sym_valid),
        .sym_bank   (sym_bank),
        .sym_release(sym_release)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Straight from the standard: first permutation i, second j, then
    // row = j / N_BPSC and pos = j mod N_BPSC.
    function automatic logic [9:0] exp_addr(input int mode, input int k, input logic bank);
        int nb, ncbps, i, s, j, row, pos;
        nb    = (mode == 0) ? 1 : (mode == 1) ? 2 : (mode == 2) ? 4 : 6;
        ncbps = 48 * nb;
        i     = (ncbps / 16) * (k % 16) + k / 16;
        s     = (nb / 2 > 1) ? nb / 2 : 1;
        j     = s * (i / s) + ((i + ncbps - (16 * i) / ncbps) % s);
        row   = j / nb;
        pos   = j % nb;
        return {bank, 6'(row), 3'(pos)};
    endfunction

    task automatic clear_hits();
        for (int a = 0; a < 1024; a++) hits[a] = 0;
    endtask

    task automatic send_dir(input logic b, input logic [9:0] ea, input string tag);
        bit_i     = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk({tag, "_wen"}, 32'(ram_wen), 32'd1);
        chk({tag, "_addr"}, 32'(ram_waddr), 32'(ea));
        chk({tag, "_data"}, 32'(ram_wdata), 32'(b));
        hits[ram_waddr]++;
    endtask

    task automatic stream(input int mode, input int nbits, input int k0, input logic bank,
                          input int sw_k, input int sw_mode, input logic rel_last);
        for (int n = 0; n < nbits; n++) begin
            int   k;
            logic b;
            k = k0 + n;
            b = 1'($urandom);
            if (k == sw_k) mod_sel = 2'(sw_mode);
            bit_i     = b;
            bit_valid = 1'b1;
            if (rel_last && n == nbits - 1) sym_release = 1'b1;
            tick();
            sym_release = 1'b0;
            chk("sweep_wen", 32'(ram_wen), 32'd1);
            chk("sweep_addr", 32'(ram_waddr), 32'(exp_addr(mode, k, bank)));
            chk("sweep_data", 32'(ram_wdata), 32'(b));
            hits[ram_waddr]++;
        end
        bit_valid = 1'b0;
    endtask

    task automatic cover_chk(input int nb, input logic bank);
        int bad;
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            int row, pos, want;
            row  = (a >> 3) & 63;
            pos  = a & 7;
            want = (((a >> 9) & 1) == int'(bank) && row < 48 && pos < nb) ? 1 : 0;
            if (hits[a] != want) bad++;
        end
        chk("sweep_cover", 32'(bad), 32'd0);
    endtask

    task automatic release_pulse();
        sym_release = 1'b1;
        tick();
        sym_release = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        mod_sel     = 2'd0;
        bit_i       = 1'b0;
        bit_valid   = 1'b0;
        sym_release = 1'b0;
        clear_hits();
        repeat (3) tick();
        chk("rst_ready", 32'(bit_ready), 32'd0);
        chk("rst_wen", 32'(ram_wen), 32'd0);
        chk("rst_addr", 32'(ram_waddr), 32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_symv", 32'(sym_valid), 32'd0);
        chk("rst_symb", 32'(sym_bank), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(bit_ready), 32'd1);
        chk("wen_after_rst", 32'(ram_wen), 32'd0);

        // BPSK into bank 0 with hand-computed addresses for k = 0, 1, 16.
        mod_sel = 2'd0;
        send_dir(1'b1, 10'h000, "bpsk_k0");
        tick();
        chk("bpsk_idle_wen", 32'(ram_wen), 32'd0);
        send_dir(1'b0, 10'h018, "bpsk_k1");
        stream(0, 14, 2, 1'b0, -1, 0, 1'b0);
        send_dir(1'b1, 10'h008, "bpsk_k16");
        stream(0, 31, 17, 1'b0, -1, 0, 1'b0);
        chk("bpsk_symv_early", 32'(sym_valid), 32'd0);
        chk("bpsk_ready", 32'(bit_ready), 32'd1);
        tick();
        chk("bpsk_symv", 32'(sym_valid), 32'd1);
        chk("bpsk_symb", 32'(sym_bank), 32'd0);
        cover_chk(1, 1'b0);

        // Bank 1 fills, both FULL, writer must stall.
        clear_hits();
        stream(0, 48, 0, 1'b1, -1, 0, 1'b0);
        chk("stall_ready", 32'(bit_ready), 32'd0);
        bit_valid = 1'b1;
        tick();
        chk("stall_wen0", 32'(ram_wen), 32'd0);
        tick();
        chk("stall_wen1", 32'(ram_wen), 32'd0);
        bit_valid = 1'b0;
        chk("stall_symv", 32'(sym_valid), 32'd1);
        chk("stall_symb", 32'(sym_bank), 32'd0);
        cover_chk(1, 1'b1);
        release_pulse();
        chk("rel_symb", 32'(sym_bank), 32'd1);
        chk("rel_ready", 32'(bit_ready), 32'd1);
        chk("rel_symv", 32'(sym_valid), 32'd1);

        // QPSK into bank 0.
        mod_sel = 2'd1;
        clear_hits();
        send_dir(1'b1, 10'h000, "qpsk_k0");
        send_dir(1'b1, 10'h018, "qpsk_k1");
        stream(1, 94, 2, 1'b0, -1, 0, 1'b0);
        chk("qpsk_ready", 32'(bit_ready), 32'd0);
        tick();
        chk("qpsk_symb", 32'(sym_bank), 32'd1);
        cover_chk(2, 1'b0);
        release_pulse();
        chk("qpsk_rel_symb", 32'(sym_bank), 32'd0);
        chk("qpsk_rel_symv", 32'(sym_valid), 32'd1);
        chk("qpsk_rel_ready", 32'(bit_ready), 32'd1);

        // 16QAM into bank 1, releasing bank 0 on the very last accept.
        mod_sel = 2'd2;
        clear_hits();
        send_dir(1'b0, 10'h200, "qam16_k0");
        send_dir(1'b1, 10'h219, "qam16_k1");
        stream(2, 190, 2, 1'b1, -1, 0, 1'b1);
        chk("coll_ready", 32'(bit_ready), 32'd1);
        chk("coll_symb", 32'(sym_bank), 32'd1);
        chk("coll_symv_early", 32'(sym_valid), 32'd0);
        tick();
        chk("coll_symv", 32'(sym_valid), 32'd1);
        chk("coll_symb2", 32'(sym_bank), 32'd1);
        cover_chk(4, 1'b1);
        release_pulse();
        chk("coll_rel_symv", 32'(sym_valid), 32'd0);
        chk("coll_rel_symb", 32'(sym_bank), 32'd0);
        release_pulse();
        chk("idle_rel_symb", 32'(sym_bank), 32'd0);

        // 64QAM into bank 0, mod_sel flips to BPSK at k=100.
        mod_sel = 2'd3;
        clear_hits();
        send_dir(1'b1, 10'h000, "qam64_k0");
        send_dir(1'b0, 10'h01A, "qam64_k1");
        stream(3, 286, 2, 1'b0, 100, 0, 1'b0);
        cover_chk(6, 1'b0);

        // Next symbol must be BPSK, in bank 1.
        clear_hits();
        stream(0, 48, 0, 1'b1, -1, 0, 1'b0);
        cover_chk(1, 1'b1);
        chk("next_ready", 32'(bit_ready), 32'd0);
        tick();
        release_pulse();
        chk("next_rel_symb", 32'(sym_bank), 32'd1);
        chk("next_rel_ready", 32'(bit_ready), 32'd1);
        release_pulse();
        chk("next_rel2_symv", 32'(sym_valid), 32'd0);

        // Reset in the middle of a symbol with bank 0 FULL.
        clear_hits();
        stream(0, 48, 0, 1'b0, -1, 0, 1'b0);
        mod_sel = 2'd1;
        stream(1, 50, 0, 1'b1, -1, 0, 1'b0);
        chk("pre_rst_symv", 32'(sym_valid), 32'd1);
        bit_valid = 1'b1;
        bit_i     = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bit_ready), 32'd0);
        chk("arst_wen", 32'(ram_wen), 32'd0);
        chk("arst_addr", 32'(ram_waddr), 32'd0);
        chk("arst_wdata", 32'(ram_wdata), 32'd0);
        chk("arst_symv", 32'(sym_valid), 32'd0);
        chk("arst_symb", 32'(sym_bank), 32'd0);
        tick();
        chk("in_rst_wen", 32'(ram_wen), 32'd0);
        chk("in_rst_ready", 32'(bit_ready), 32'd0);
        rst       = 1'b0;
        bit_valid = 1'b0;
        tick();
        chk("post_rst_ready", 32'(bit_ready), 32'd1);
        chk("post_rst_wen", 32'(ram_wen), 32'd0);
        chk("post_rst_symv", 32'(sym_valid), 32'd0);
        mod_sel = 2'd0;
        send_dir(1'b1, 10'h000, "post_rst_k0");
        send_dir(1'b0, 10'h018, "post_rst_k1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
